niossoc_key_pio_in: RTL and testbench

- Avalon-MM slave input PIO for the DE2 push-buttons and switches. It is the read-side counterpart of the SoC's LED output PIO.
- Signal path:
  - Samples the asynchronous in_port pins.
  - Synchronises them and debounces each bit.
  - Exposes the debounced level to the Nios II.
  - Latches selected edges into a sticky edge-capture register.
  - Raises a maskable level interrupt.

---
 rtl/niossoc_key_pio_in_if.sv | 31 +++
 rtl/niossoc_key_pio_in.sv | 123 ++++++++++++
 tb/tb_niossoc_key_pio_in.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/niossoc_key_pio_in_if.sv
// Avalon-MM slave port bundle for the key/switch input PIO.
// The CPU side (master) drives the strobes; the PIO (slave) returns readdata and irq.
interface niossoc_key_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport slave (
        input  address,
        input  chipselect,
        input  read_n,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

    modport master (
        output address,
        output chipselect,
        output read_n,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );
endinterface

// File: rtl/niossoc_key_pio_in.sv
// Input PIO for DE2 keys/switches: 2-flop synchroniser, per-bit debounce,
// sticky edge capture with W1C clear, and a maskable level interrupt.
module niossoc_key_pio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int INIT_LEVEL      = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    niossoc_key_pio_in_if.slave     avs,
    input  logic [WIDTH-1:0]        in_port
);

    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [WIDTH-1:0] INIT_VEC = (INIT_LEVEL != 0) ? '1 : '0;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_prev_q, stable_prev_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] rise, fall, edge_sel;
    logic [31:0]      wdata;
    logic             rd_en, wr_en;
    logic             unused_wdata;

    assign wdata        = avs.writedata;
    assign unused_wdata = ^wdata;
    assign rd_en        = avs.chipselect & ~avs.read_n;
    assign wr_en        = avs.chipselect & ~avs.write_n;

    always_comb begin
        sync1_d       = in_port;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
        end
        if (DEBOUNCE_CYCLES == 0) begin
            stable_d = sync2_q;
        end else begin
            // A bit is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        stable_d[i] = sync2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        rise = stable_q & ~stable_prev_q;
        fall = ~stable_q & stable_prev_q;
        case (EDGE_TYPE)
            0:       edge_sel = rise;
            1:       edge_sel = fall;
            default: edge_sel = rise | fall;
        endcase

        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && avs.address == 2'd2) begin
            irqmask_d = wdata[WIDTH-1:0];
        end
        if (wr_en && avs.address == 2'd3) begin
            edgecap_d = edgecap_q & ~wdata[WIDTH-1:0];
        end
        // Set after clear so a new edge wins over a same-cycle W1C.
        edgecap_d = edgecap_d | edge_sel;

        readdata_d = '0;
        if (rd_en) begin
            case (avs.address)
                2'd0:    readdata_d[WIDTH-1:0] = stable_q;
                2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
                2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= INIT_VEC;
            sync2_q       <= INIT_VEC;
            stable_q      <= INIT_VEC;
            stable_prev_q <= INIT_VEC;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            irqmask_q     <= '0;
            edgecap_q     <= '0;
            readdata_q    <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            irqmask_q     <= irqmask_d;
            edgecap_q     <= edgecap_d;
            readdata_q    <= readdata_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign avs.irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_niossoc_key_pio_in.sv
// Directed bench for the key input PIO with a short debounce (4 cycles).
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_niossoc_key_pio_in;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;
    logic [31:0] rd;
    int         errors;
    int         checks;

    niossoc_key_pio_in_if bus ();

    niossoc_key_pio_in #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE      (1),
        .INIT_LEVEL     (1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .avs    (bus.slave),
        .in_port(in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data           = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset_n        = 1'b0;
        in_port        = 4'hF;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        idle(3);
        reset_n = 1'b1;
        idle(2);

        // Reset state
        check_output("reset_irq", {31'b0, bus.irq}, 32'h0);
        bus_read(2'd0, rd); check_output("reset_data", rd, 32'hF);
        bus_read(2'd1, rd); check_output("reset_rsvd", rd, 32'h0);
        bus_read(2'd2, rd); check_output("reset_mask", rd, 32'h0);
        bus_read(2'd3, rd); check_output("reset_edge", rd, 32'h0);

        // Falling bit0: stable changes at edge k+5, visible in a read at k+6
        in_port = 4'hE;
        for (int i = 0; i < 6; i++) bus_read(2'd0, rd);
        check_output("deb_not_early", rd, 32'hF);
        bus_read(2'd0, rd); check_output("deb_accepted", rd, 32'hE);
        bus_read(2'd3, rd); check_output("fall_captured", rd, 32'h1);
        check_output("irq_masked", {31'b0, bus.irq}, 32'h0);

        // Two 3-cycle glitches on bit1 separated by one high cycle
        in_port = 4'hC; idle(3);
        in_port = 4'hE; idle(1);
        in_port = 4'hC; idle(3);
        in_port = 4'hE; idle(8);
        bus_read(2'd0, rd); check_output("glitch_data", rd, 32'hE);
        bus_read(2'd3, rd); check_output("glitch_edge", rd, 32'h1);

        // Interrupt path
        in_port = 4'hF; idle(8);
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'hFFFF_FFF1);
        bus_read(2'd2, rd); check_output("mask_upper_ignored", rd, 32'h1);
        check_output("irq_idle", {31'b0, bus.irq}, 32'h0);
        in_port = 4'hE;
        idle(6);
        check_output("irq_before_set", {31'b0, bus.irq}, 32'h0);
        idle(1);
        check_output("irq_on_set", {31'b0, bus.irq}, 32'h1);
        bus_write(2'd3, 32'h2);
        check_output("irq_other_w1c", {31'b0, bus.irq}, 32'h1);
        bus_read(2'd3, rd); check_output("w1c_other_bit", rd, 32'h1);
        bus_write(2'd3, 32'h1);
        check_output("irq_cleared", {31'b0, bus.irq}, 32'h0);

        // Set wins over W1C; concurrent read returns pre-clear value
        in_port = 4'h6; idle(10);
        bus_read(2'd3, rd); check_output("bit3_captured", rd, 32'h8);
        in_port = 4'h2;
        idle(6);
        bus.address    = 2'd3;
        bus.writedata  = 32'hC;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("read_pre_clear", bus.readdata, 32'h8);
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus_read(2'd3, rd); check_output("set_wins", rd, 32'h4);
        check_output("irq_bit2_masked", {31'b0, bus.irq}, 32'h0);

        // Reset in the middle of a debounce count
        in_port = 4'hF; idle(10);
        bus_write(2'd3, 32'hF);
        in_port = 4'hE; idle(3);
        reset_n = 1'b0; idle(2);
        reset_n = 1'b1;
        bus_read(2'd0, rd); check_output("rst_data", rd, 32'hF);
        bus_read(2'd3, rd); check_output("rst_no_edge", rd, 32'h0);
        bus_read(2'd2, rd); check_output("rst_mask", rd, 32'h0);
        check_output("rst_irq", {31'b0, bus.irq}, 32'h0);
        bus_read(2'd0, rd);
        bus_read(2'd0, rd);
        bus_read(2'd0, rd); check_output("rst_restart_not_early", rd, 32'hF);
        bus_read(2'd0, rd); check_output("rst_reaccepted", rd, 32'hE);
        bus_read(2'd3, rd); check_output("rst_edge_after", rd, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
